mata_loader: RTL and testbench
==============================

Name: mata_loader

Overview:
- Upstream sequencer for the A-matrix store (memA, BITS_AB/DEPTH parameterised).
- Accepts a DEPTH x DEPTH signed matrix as a row-major element stream over a valid/ready handshake.
- Drives memA's write port (WrEn/row/col/Ain) one element per accepted beat.
- Once the last element is written, asserts memA's en for a fixed streaming window so memA feeds the systolic array, then pulses done.

Parameters:
- BITS_AB, 8, element width in bits (signed).
- DEPTH, 8, matrix dimension; the matrix holds DEPTH*DEPTH elements.
- STREAM_CYCLES, 3*DEPTH, number of consecutive cycles en is held high.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  1-cycle request to begin a load; sampled only in IDLE.
- in_valid  input  1  in_data holds a valid element.
- in_ready  output  1  loader accepts an element this cycle.
- in_data  input  BITS_AB  signed element, row-major order.
- WrEn  output  1  memA write enable.
- row  output  $clog2(DEPTH)  memA write row.
- col  output  $clog2(DEPTH)  memA write column.
- Ain  output  BITS_AB  memA write data (signed).
- en  output  1  memA output/stream enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  1-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock. While rst is high:
  - state = IDLE.
  - WrEn, en, done, in_ready, busy, row, col, Ain and the internal counters are all 0.
  - Reset asserted mid-operation aborts immediately. No further WrEn or en is issued, and done is not pulsed.
- All outputs are registered except in_ready, which is combinational: (state == LOAD).
- States and transitions:
  - IDLE: on start=1, go to LOAD and clear the element counters (r_cnt, c_cnt) to 0. Otherwise stay in IDLE.
  - LOAD: a beat is accepted when in_valid && in_ready.
    - On accept, the next cycle shows WrEn=1, row=r_cnt, col=c_cnt, Ain=in_data (1-cycle latency).
    - With no accept, the next cycle shows WrEn=0. row, col and Ain hold their last values.
    - Counter update on accept: c_cnt increments. When c_cnt==DEPTH-1 it wraps to 0 and r_cnt increments.
    - The accept of element (DEPTH-1, DEPTH-1) moves the state to GAP.
  - GAP: exactly 1 cycle, during which the final WrEn=1 is visible. in_ready=0. Next state is STREAM.
  - STREAM: en=1 for exactly STREAM_CYCLES consecutive cycles, counted by a $clog2(STREAM_CYCLES+1)-bit counter. WrEn=0 throughout. Next state is DONE.
  - DONE: done=1 for exactly 1 cycle, en=0. Next state is IDLE. busy drops in the cycle done is low again.
- start while busy=1 is ignored; it is neither queued nor restarts the load.
- start in the same cycle DONE returns to IDLE is ignored. start on any later cycle is accepted.
- in_valid outside LOAD is ignored, and no data is consumed.
- Gaps in in_valid stall the load indefinitely; there is no timeout.
- Element order is strictly row-major: element k goes to row k/DEPTH, col k%DEPTH.
- Ain carries in_data unmodified, with no sign extension or truncation.
- WrEn and en are never high in the same cycle.

Test Plan:
- Reset values: hold rst=1 for 3 cycles with random inputs, including start=1 → every output stays 0. After release with no start, all outputs stay 0 for 10 cycles.
- Contiguous load (DEPTH=8): start, then 64 beats with in_valid=1 every cycle carrying values k-32 → WrEn high for exactly 64 consecutive cycles, row/col stepping 0,0 … 7,7. en then stays high for exactly 24 cycles, starting the cycle after the last WrEn. done pulses once. A reference memA loaded by the bench matches the 8x8 matrix.
- Stalled load: in_valid toggles 1,0,0,1 pseudo-randomly → WrEn count is 64. There are no duplicate or skipped (row,col) pairs. Write values at (3,5)=-128 and (7,7)=127 are correct.
- start during LOAD and during STREAM → no restart; the en window stays exactly 24 cycles; done pulses once.
- Reset at the 20th accepted beat → outputs go to 0 immediately. A following full load starts again at row 0 col 0 and completes normally.
- Back-to-back: start asserted the cycle after done deasserts → the second load begins. Two done pulses total, with en windows of 24 cycles each.

Source files
------------

// File: rtl/mata_loader.sv
// Upstream sequencer for the A-matrix store: takes a row-major element stream,
// writes memA one element per beat, then opens the stream window and pulses done.
module mata_loader #(
    parameter int unsigned BITS_AB       = 8,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned STREAM_CYCLES = 3 * DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITS_AB-1:0]       in_data,
    output logic                     WrEn,
    output logic [$clog2(DEPTH)-1:0] row,
    output logic [$clog2(DEPTH)-1:0] col,
    output logic [BITS_AB-1:0]       Ain,
    output logic                     en,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(STREAM_CYCLES + 1);
    localparam logic [AW-1:0] LastIdx    = AW'(DEPTH - 1);
    localparam logic [SW-1:0] LastStream = SW'(STREAM_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGap,
        StStream,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   r_cnt_q, r_cnt_d;
    logic [AW-1:0]   c_cnt_q, c_cnt_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic            accept;

    assign in_ready = (state_q == StLoad);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        r_cnt_d = r_cnt_q;
        c_cnt_d = c_cnt_q;
        s_cnt_d = s_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    r_cnt_d = '0;
                    c_cnt_d = '0;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (c_cnt_q == LastIdx) begin
                        c_cnt_d = '0;
                        r_cnt_d = r_cnt_q + 1'b1;
                        // Accepting the bottom-right element ends the load.
                        if (r_cnt_q == LastIdx) begin
                            state_d = StGap;
                        end
                    end else begin
                        c_cnt_d = c_cnt_q + 1'b1;
                    end
                end
            end
            StGap: begin
                state_d = StStream;
                s_cnt_d = '0;
            end
            StStream: begin
                if (s_cnt_q == LastStream) begin
                    state_d = StDone;
                end else begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            r_cnt_q <= '0;
            c_cnt_q <= '0;
            s_cnt_q <= '0;
            WrEn    <= 1'b0;
            row     <= '0;
            col     <= '0;
            Ain     <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_cnt_q <= r_cnt_d;
            c_cnt_q <= c_cnt_d;
            s_cnt_q <= s_cnt_d;
            WrEn    <= accept;
            if (accept) begin
                row <= r_cnt_q;
                col <= c_cnt_q;
                Ain <= in_data;
            end
            en   <= (state_d == StStream);
            busy <= (state_d != StIdle);
            done <= (state_d == StDone);
        end
    end

endmodule

// File: tb/tb_mata_loader.sv
// Scoreboard bench for mata_loader: driver pushes expected memA writes, a negedge
// monitor pops and compares them and polices the en window and done pulse.
module tb_mata_loader;

    localparam int DEPTH = 8;
    localparam int SC    = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, wr_en, en, busy, done;
    logic [2:0] row, col;
    logic [7:0] ain;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] c;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] ref_mem[DEPTH][DEPTH];
    int total = 0, bad = 0;
    int wr_cnt = 0, wr_run = 0, last_wr_run = 0;
    int en_run = 0, en_win = 0, done_cnt = 0;
    logic prev_wr = 1'b0;

    mata_loader #(.BITS_AB(8), .DEPTH(DEPTH), .STREAM_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .WrEn(wr_en), .row(row), .col(col), .Ain(ain), .en(en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            wr_run  = 0;
            en_run  = 0;
            prev_wr = 1'b0;
        end else begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_row_col_data", {row, col, ain}, {e.r, e.c, e.d});
                end
                ref_mem[row][col] = ain;
                wr_cnt++;
                wr_run++;
            end else if (wr_run != 0) begin
                last_wr_run = wr_run;
                wr_run = 0;
            end
            if (wr_en || en) check("wr_en_excl", wr_en && en, 0);
            if (en) begin
                if (en_run == 0) check("en_after_last_wr", prev_wr, 1);
                en_run++;
            end else if (en_run != 0) begin
                check("en_window", en_run, SC);
                en_win++;
                en_run = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_no_en", en, 0);
            end
            prev_wr = wr_en;
        end
    end

    function automatic logic [7:0] val(input int mode, input int k);
        case (mode)
            0: return 8'(k - 32);
            1: return (k == 29) ? 8'h80 : (k == 63) ? 8'h7f : 8'(k * 5 - 100);
            default: return 8'(63 - k);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic beat(input int idx, input logic [7:0] v);
        int t = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_seen", in_ready, 1);
        if (in_ready) exp_q.push_back('{r: 3'(idx / DEPTH), c: 3'(idx % DEPTH), d: v});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input int mode, input int nbeats, input int start_at);
        for (int k = 0; k < nbeats; k++) begin
            if (k == start_at) start = 1'b1;
            beat(k, val(mode, k));
            start = 1'b0;
            if (mode == 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", done, 1);
        @(negedge clk);
        #1;
        check("busy_after_done", busy, 0);
    endtask

    int d0, w0, c0;

    task automatic snap();
        d0 = done_cnt;
        w0 = en_win;
        c0 = wr_cnt;
    endtask

    task automatic check_run(input int ndone, input int nwr);
        check("done_count", done_cnt - d0, ndone);
        check("en_windows", en_win - w0, ndone);
        check("wr_count", wr_cnt - c0, nwr);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        // Reset with noisy inputs, including start.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start    = 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            #1;
            check("reset_outs", {in_ready, wr_en, row, col, ain, en, busy, done}, 0);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            check("idle_outs", {in_ready, wr_en, row, col, ain, en, busy, done}, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Contiguous load.
        snap();
        go();
        load(0, 64, -1);
        wait_done();
        check_run(1, 64);
        check("wr_contiguous", last_wr_run, 64);
        for (int r = 0; r < DEPTH; r++)
            for (int c = 0; c < DEPTH; c++)
                check("memA", ref_mem[r][c], val(0, r * DEPTH + c));

        // Stalled load.
        snap();
        go();
        load(1, 64, -1);
        wait_done();
        check_run(1, 64);
        check("memA_3_5", ref_mem[3][5], 8'h80);
        check("memA_7_7", ref_mem[7][7], 8'h7f);

        // start during LOAD and during STREAM is ignored.
        snap();
        go();
        load(0, 64, 10);
        begin
            int t = 0;
            while (!en && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        check("en_reached", en, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        #1;
        check("no_restart", busy, 0);
        check_run(1, 64);

        // Reset after the 20th accepted beat.
        @(negedge clk);
        snap();
        go();
        load(2, 20, -1);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_outs", {in_ready, wr_en, row, col, ain, en, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_run(0, 20);
        check("midreset_idle", busy, 0);
        snap();
        go();
        load(2, 64, -1);
        wait_done();
        check_run(1, 64);
        check("memA_0_0", ref_mem[0][0], 8'd63);

        // Back-to-back loads.
        snap();
        go();
        load(0, 64, -1);
        wait_done();
        go();
        load(1, 64, -1);
        wait_done();
        check_run(2, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
